// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit 1, WIDTH data bits LSB-first, optional parity, stop bit 0.
// Completed words are offered on a valid/ready port through a single-entry holding register.
module sipo_frame_rx #(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt;
  logic             par_q;
  logic             good_stop, bad_stop;
  logic             load, drop, calc_perr;

  // Handshake: a word transfers on any rising edge where out_valid=1 and out_ready=1.
  // A good frame loads only if the holding register is empty or being emptied on that edge.
  assign load      = good_stop && (!out_valid || out_ready);
  assign drop      = good_stop && out_valid && !out_ready;
  assign calc_perr = (PARITY_EN != 0) && (par_q != ((^shift_q) ^ (ODD_PARITY != 0)));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      IDLE:   if (sin) state_nx = DATA;
      DATA: begin
        if (cnt == LAST_BIT) begin
          if (PARITY_EN != 0) state_nx = PARITY;
          else                state_nx = STOP;
        end
      end
      PARITY: state_nx = STOP;
      STOP: begin
        // A 1 in the stop slot is a framing error, never a new start bit.
        state_nx  = IDLE;
        good_stop = !sin;
        bad_stop  = sin;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt     <= '0;
      par_q   <= 1'b0;
    end else begin
      case (state)
        IDLE:   cnt <= '0;
        DATA: begin
          // Right shift: the first data bit ends up in bit 0 after WIDTH shifts.
          shift_q <= {sin, shift_q[WIDTH-1:1]};
          cnt     <= cnt + 1'b1;
        end
        PARITY: par_q <= sin;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= drop;
      if (load) begin
        out_data   <= shift_q;
        parity_err <= calc_perr;
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx (WIDTH=8, even parity): directed frames, scoreboard of delivered words.
module tb_sipo_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cycles = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  // Expected delivered words: {parity_err, data}
  logic [8:0] exp_q[$];

  sipo_frame_rx #(.WIDTH(8), .PARITY_EN(1), .ODD_PARITY(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  // rdy_stop < 0 leaves out_ready alone; otherwise it is applied for the stop-bit edge.
  task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop,
                            input int rdy_stop);
    send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ flip_par);
    if (rdy_stop >= 0) out_ready = rdy_stop[0];
    send_bit(stop);
  endtask

  // Monitor: pops and compares on every transfer the DUT will take at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) valid_cycles++;
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", {parity_err, out_data});
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("word", {23'd0, parity_err, out_data}, {23'd0, e});
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Good 0xA5 frame, even parity 0, out_valid for exactly one cycle
    valid_cycles = 0;
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b0, 1'b0, -1);
    check("a5_valid_after_stop", out_valid, 1);
    check("a5_busy_after_stop", busy, 0);
    idle(3);
    check("a5_valid_cycles", valid_cycles, 1);
    check("a5_valid_low", out_valid, 0);

    // Parity bit flipped: still delivered, flagged
    exp_q.push_back({1'b1, 8'hA5});
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    check("perr_ferr", frame_err, 0);
    idle(3);

    // Bad stop: frame_err pulse, nothing delivered; next frame good
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    check("ferr_pulse", frame_err, 1);
    check("ferr_valid", out_valid, 0);
    check("ferr_idle", busy, 0);
    idle(1);
    check("ferr_one_cycle", frame_err, 0);
    check("ferr_busy_after", busy, 0);
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b0, 1'b0, -1);
    idle(3);

    // Overrun: 0x11 held, back-to-back 0x22 dropped
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h11});
    send_frame(8'h11, 1'b0, 1'b0, -1);
    send_frame(8'h22, 1'b0, 1'b0, -1);
    check("ovr_pulse", overrun, 1);
    check("ovr_data_held", out_data, 8'h11);
    check("ovr_valid_held", out_valid, 1);
    idle(1);
    check("ovr_one_cycle", overrun, 0);
    idle(2);
    check("ovr_still_held", out_data, 8'h11);
    out_ready = 1'b1;
    idle(1);
    check("ovr_drain_valid", out_valid, 0);
    idle(2);

    // Ready raised exactly on the edge that completes the next word
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h11});
    send_frame(8'h11, 1'b0, 1'b0, -1);
    idle(2);
    exp_q.push_back({1'b0, 8'h22});
    send_frame(8'h22, 1'b0, 1'b0, 1);
    check("swap_valid", out_valid, 1);
    check("swap_data", out_data, 8'h22);
    check("swap_ovr", overrun, 0);
    idle(3);
    check("swap_drained", out_valid, 0);

    // Asynchronous reset mid-frame, with a held word that reset discards
    out_ready = 1'b0;
    send_frame(8'h77, 1'b0, 1'b0, -1);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_busy", busy, 0);
    check("arst_perr", parity_err, 0);
    sin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b0, -1);
    idle(4);

    check("frame_err_count", fe_cnt, 1);
    check("overrun_count", ov_cnt, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Serial-to-parallel frame receiver that sits directly downstream of the SISO shift register and consumes its serial output Q.
- Detects a start bit, shifts in WIDTH data bits LSB-first, then checks an optional parity bit and a stop bit.
- Presents each completed word on a valid/ready parallel port through a single-entry holding register.
- Reports parity, framing and overrun errors.

Parameters:
WIDTH, 8, number of data bits per frame (2..32)
PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit
ODD_PARITY, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
sin  input  1  serial bit stream (driven by the SISO Q); one bit per clk
out_data  output  WIDTH  received word held in the output register
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts the word on an edge where out_valid=1
parity_err  output  1  parity mismatch flag for the word in out_data; qualified by out_valid
frame_err  output  1  one-cycle pulse: stop bit was 1, frame discarded
overrun  output  1  one-cycle pulse: completed frame dropped because the holding register was full
busy  output  1  high while state != IDLE

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately forces state=IDLE and clears the shift register, bit counter, out_data, out_valid, parity_err, frame_err and overrun to 0. busy is 0.
- Reset asserted mid-frame discards the partial frame. No output is produced for it.
- Line format: idle level 0, start bit 1, data LSB-first, optional parity, stop bit 0. One bit is sampled per rising edge; there is no oversampling.
- FSM states are IDLE, DATA, PARITY and STOP.
  - IDLE: if sin=1, go to DATA with bit counter=0. Otherwise stay.
  - DATA: shift sin into bit[counter]. After WIDTH bits, go to PARITY if PARITY_EN, else go to STOP.
  - PARITY: capture sin. Go to STOP.
  - STOP: if sin=0, the frame is good and is delivered. If sin=1, assert frame_err for one cycle and drop the frame. The stop-position 1 is NOT reinterpreted as a start bit. Always return to IDLE.
- Frame length: 1 + WIDTH + PARITY_EN + 1 bits.
- Latency: out_valid rises in the cycle after the edge that samples the stop bit.
- Parity check: computed = XOR of the data bits XOR ODD_PARITY. parity_err = (received parity != computed). It is loaded together with out_data. Always 0 when PARITY_EN=0.
- A parity error does not drop the frame; the word is still delivered.
- Handshake: a transfer occurs on an edge where out_valid=1 and out_ready=1. If no new word loads on that edge, out_valid clears.
- out_data and parity_err are stable while out_valid=1 and out_ready=0.
- Good stop with out_valid=0: load the new word and set out_valid.
- Good stop with out_valid=1 and out_ready=1 on the same edge: the old word transfers, the new word loads, and out_valid stays 1.
- Good stop with out_valid=1 and out_ready=0: drop the new word, keep the old word, and pulse overrun for one cycle.
- Back-to-back frames: a start bit on the cycle immediately after the stop bit is accepted, giving zero idle gap.
- frame_err and overrun are mutually exclusive per frame. A framing error never raises overrun.
- busy is combinationally (state != IDLE).

Test Plan:
- WIDTH=8, PARITY_EN=1, even parity. sin = 1, then bits 1,0,1,0,0,1,0,1, then parity 0, then stop 0, out_ready=1 → out_data=0xA5, parity_err=0, out_valid high for exactly 1 cycle starting the cycle after the 11th edge.
- Same frame with the parity bit flipped to 1 → out_data=0xA5 delivered, parity_err=1, no frame_err.
- 0x3C frame with stop bit=1 → frame_err pulses 1 cycle, out_valid stays 0, FSM returns to IDLE. A following valid 0x81 frame is received correctly.
- out_ready=0. Send 0x11 then 0x22 back-to-back → out_data=0x11 held, overrun pulses once at the 0x22 stop edge. Raising out_ready then transfers 0x11, and out_valid drops.
- out_valid=1 holding 0x11, out_ready=1 exactly on the edge that completes 0x22 → 0x11 consumed, out_data=0x22, out_valid stays 1, overrun=0.
- rst_n pulsed low asynchronously after 4 data bits of a frame → all outputs 0 immediately. The partial frame is never delivered, and the next full 0x5A frame is received correctly.
